// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO register bank: address field layout, CTRL bits, default sizes.
package mmio_pkg;

    localparam int unsigned NUM_CH_DEF      = 16;
    localparam int unsigned REGS_PER_CH_DEF = 8;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned ADDR_W_DEF      = 13;
    localparam int unsigned CH_BITS_DEF     = 4;
    localparam int unsigned REG_BITS_DEF    = 3;

    localparam int unsigned REG_LSB     = 2;
    localparam int unsigned CH_LSB_DEF  = REG_LSB + REG_BITS_DEF;
    localparam int unsigned S_BIT_DEF   = CH_LSB_DEF + CH_BITS_DEF;

    localparam int unsigned CTRL_COMMIT = 0;
    localparam int unsigned CTRL_AUTO   = 1;

    typedef enum logic [1:0] {
        AccData,
        AccCtrl,
        AccStatus
    } acc_kind_e;

    function automatic int unsigned ch_lsb(int unsigned reg_bits);
        return REG_LSB + reg_bits;
    endfunction

    function automatic int unsigned s_bit(int unsigned reg_bits, int unsigned ch_bits);
        return REG_LSB + reg_bits + ch_bits;
    endfunction

endpackage

// File: rtl/mmio_channel.sv
// One channel: double-buffered config (shadow/active), auto-commit flag, sampled status
// word with a sticky change flag, and the per-slot change pulses.
module mmio_channel
    import mmio_pkg::*;
#(
    parameter int unsigned REGS_PER_CH = REGS_PER_CH_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned REG_BITS    = REG_BITS_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                wr_i,
    input  logic                                clr_i,
    input  logic [REG_BITS-1:0]                 reg_i,
    input  logic [DATA_W-1:0]                   wdata_i,
    input  logic [DATA_W-1:0]                   status_i,
    output logic [(REGS_PER_CH-1)*DATA_W-1:0]   active_o,
    output logic [(REGS_PER_CH-1)*DATA_W-1:0]   shadow_o,
    output logic                                auto_o,
    output logic [DATA_W-1:0]                   status_o,
    output logic [REGS_PER_CH-2:0]              wr_pulse_o,
    output logic                                commit_pulse_o,
    output logic                                evt_pending_o
);

    localparam int unsigned NData = REGS_PER_CH - 1;

    logic [NData-1:0][DATA_W-1:0] shadow_q, shadow_d;
    logic [NData-1:0][DATA_W-1:0] active_q, active_d;
    logic                         auto_q, auto_d;
    logic [DATA_W-1:0]            status_q;
    logic                         evt_q, evt_d;
    logic [NData-1:0]             wr_pulse_q, wr_pulse_d;
    logic                         commit_q, commit_d;

    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        auto_d     = auto_q;
        wr_pulse_d = '0;
        commit_d   = 1'b0;
        if (wr_i) begin
            if (reg_i == REG_BITS'(NData)) begin
                auto_d = wdata_i[CTRL_AUTO];
                // Commit bit is a strobe only; it is never stored.
                if (wdata_i[CTRL_COMMIT]) begin
                    commit_d = 1'b1;
                    active_d = shadow_q;
                    for (int i = 0; i < NData; i++) begin
                        wr_pulse_d[i] = (shadow_q[i] != active_q[i]);
                    end
                end
            end else begin
                for (int i = 0; i < NData; i++) begin
                    if (reg_i == REG_BITS'(i)) begin
                        shadow_d[i] = wdata_i;
                        if (auto_q) begin
                            active_d[i]   = wdata_i;
                            wr_pulse_d[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // A fresh status change outranks a clearing read in the same cycle.
    assign evt_d = (status_i != status_q) | (evt_q & ~clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q   <= '0;
            active_q   <= '0;
            auto_q     <= 1'b0;
            status_q   <= '0;
            evt_q      <= 1'b0;
            wr_pulse_q <= '0;
            commit_q   <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            auto_q     <= auto_d;
            status_q   <= status_i;
            evt_q      <= evt_d;
            wr_pulse_q <= wr_pulse_d;
            commit_q   <= commit_d;
        end
    end

    assign active_o       = active_q;
    assign shadow_o       = shadow_q;
    assign auto_o         = auto_q;
    assign status_o       = status_q;
    assign wr_pulse_o     = wr_pulse_q;
    assign commit_pulse_o = commit_q;
    assign evt_pending_o  = evt_q;

endmodule

// File: rtl/mmio_bank.sv
// MMIO register bank for NUM_CH coprocessor channels: address decode, registered read
// path, illegal-address error pulse and the global status interrupt.
module mmio_bank
    import mmio_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned REGS_PER_CH = REGS_PER_CH_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned CH_BITS     = CH_BITS_DEF,
    parameter int unsigned REG_BITS    = REG_BITS_DEF
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        req_valid_i,
    input  logic                                        req_wren_i,
    input  logic [ADDR_W-1:0]                           req_addr_i,
    input  logic [DATA_W-1:0]                           req_wdata_i,
    output logic                                        rd_valid_o,
    output logic [DATA_W-1:0]                           rd_data_o,
    output logic                                        err_o,
    output logic [NUM_CH*(REGS_PER_CH-1)*DATA_W-1:0]    cfg_active_o,
    output logic [NUM_CH*(REGS_PER_CH-1)-1:0]           wr_pulse_o,
    output logic [NUM_CH-1:0]                           commit_pulse_o,
    input  logic [NUM_CH*DATA_W-1:0]                    status_i,
    output logic [NUM_CH-1:0]                           evt_pending_o,
    output logic                                        irq_o
);

    localparam int unsigned NData = REGS_PER_CH - 1;
    localparam int unsigned ChLsb = ch_lsb(REG_BITS);
    localparam int unsigned SBit  = s_bit(REG_BITS, CH_BITS);

    logic [REG_BITS-1:0] reg_sel;
    logic [CH_BITS-1:0]  ch_sel;
    logic                s_sel;
    logic                accept;
    logic                legal;
    acc_kind_e           kind;

    logic [NUM_CH-1:0]              ch_wr;
    logic [NUM_CH-1:0]              ch_clr;
    logic [NUM_CH-1:0]              ch_auto;
    logic [NData*DATA_W-1:0]        ch_shadow [NUM_CH];
    logic [DATA_W-1:0]              ch_status [NUM_CH];

    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                err_q, err_d;
    logic                irq_q;

    // Byte-lane bits and the gap above the status-space bit carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^req_addr_i;

    assign reg_sel = req_addr_i[REG_LSB +: REG_BITS];
    assign ch_sel  = req_addr_i[ChLsb +: CH_BITS];
    assign s_sel   = req_addr_i[SBit];
    assign accept  = req_valid_i & req_addr_i[ADDR_W-1];
    assign legal   = (32'(ch_sel) < NUM_CH) & (s_sel | (32'(reg_sel) < REGS_PER_CH));

    always_comb begin
        kind = AccData;
        if (s_sel) begin
            kind = AccStatus;
        end else if (reg_sel == REG_BITS'(NData)) begin
            kind = AccCtrl;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_wr[c]  = accept & legal & req_wren_i & ~s_sel & (ch_sel == CH_BITS'(c));
        assign ch_clr[c] = accept & legal & ~req_wren_i & s_sel & (ch_sel == CH_BITS'(c));

        mmio_channel #(
            .REGS_PER_CH (REGS_PER_CH),
            .DATA_W      (DATA_W),
            .REG_BITS    (REG_BITS)
        ) u_channel (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .wr_i           (ch_wr[c]),
            .clr_i          (ch_clr[c]),
            .reg_i          (reg_sel),
            .wdata_i        (req_wdata_i),
            .status_i       (status_i[c*DATA_W +: DATA_W]),
            .active_o       (cfg_active_o[c*NData*DATA_W +: NData*DATA_W]),
            .shadow_o       (ch_shadow[c]),
            .auto_o         (ch_auto[c]),
            .status_o       (ch_status[c]),
            .wr_pulse_o     (wr_pulse_o[c*NData +: NData]),
            .commit_pulse_o (commit_pulse_o[c]),
            .evt_pending_o  (evt_pending_o[c])
        );
    end

    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = accept & ~req_wren_i;
        err_d      = accept & ~legal;
        if (accept && !req_wren_i && legal) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel == CH_BITS'(c)) begin
                    unique case (kind)
                        AccStatus: rd_data_d = ch_status[c];
                        AccCtrl:   rd_data_d[CTRL_AUTO] = ch_auto[c];
                        default: begin
                            for (int i = 0; i < NData; i++) begin
                                if (reg_sel == REG_BITS'(i)) begin
                                    rd_data_d = ch_shadow[c][i*DATA_W +: DATA_W];
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            irq_q      <= |evt_pending_o;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign err_o      = err_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_mmio_bank.sv
// Directed bench for mmio_bank with 12 channels, so channels 12..15 decode as illegal.
module tb_mmio_bank;

    localparam int unsigned NCH = 12;
    localparam int unsigned RPC = 8;
    localparam int unsigned ND  = RPC - 1;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 13;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_wren;
    logic [AW-1:0]         req_addr;
    logic [DW-1:0]         req_wdata;
    logic                  rd_valid;
    logic [DW-1:0]         rd_data;
    logic                  err;
    logic [NCH*ND*DW-1:0]  cfg_active;
    logic [NCH*ND-1:0]     wr_pulse;
    logic [NCH-1:0]        commit_pulse;
    logic [NCH*DW-1:0]     status_in;
    logic [NCH-1:0]        evt_pending;
    logic                  irq;

    logic [NCH*ND*DW-1:0]  exp_cfg;
    logic [NCH*ND-1:0]     exp_wp;
    int total;
    int bad;

    mmio_bank #(
        .NUM_CH      (NCH),
        .REGS_PER_CH (RPC),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .CH_BITS     (4),
        .REG_BITS    (3)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_wren_i     (req_wren),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .err_o          (err),
        .cfg_active_o   (cfg_active),
        .wr_pulse_o     (wr_pulse),
        .commit_pulse_o (commit_pulse),
        .status_i       (status_in),
        .evt_pending_o  (evt_pending),
        .irq_o          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_wren  = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_wren  = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic v, output logic e);
        @(negedge clk);
        req_valid = 1'b1;
        req_wren  = 1'b0;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        d = rd_data;
        v = rd_valid;
        e = err;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        logic v, e;
        repeat (2) @(negedge clk);
        total++;
        if (cfg_active !== '0) begin
            bad++;
            $display("FAIL reset_cfg: %0d bits set, want 0", $countones(cfg_active));
        end
        total++;
        if ({irq, rd_valid, err, evt_pending, commit_pulse} !== '0) begin
            bad++;
            $display("FAIL reset_flags: irq=%b rd_valid=%b err=%b evt=%h commit=%h, want all 0",
                     irq, rd_valid, err, evt_pending, commit_pulse);
        end
        rst_n = 1'b1;
        bus_read(13'h1000, d, v, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL reset_read: valid=%b data=%h, want 1 00000000", v, d);
        end
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL read_idle: valid=%b data=%h, want 0 00000000", rd_valid, rd_data);
        end
    endtask

    task automatic test_manual_commit();
        logic [DW-1:0] d;
        logic v, e;
        bus_write(13'h100C, 32'h016000FA);
        total++;
        if (cfg_active !== exp_cfg || wr_pulse !== '0) begin
            bad++;
            $display("FAIL shadow_only: cfg diff bits=%0d wr_pulse=%h, want 0 0",
                     $countones(cfg_active ^ exp_cfg), wr_pulse);
        end
        bus_read(13'h100C, d, v, e);
        total++;
        if (v !== 1'b1 || d !== 32'h016000FA) begin
            bad++;
            $display("FAIL shadow_read: valid=%b data=%h, want 1 016000fa", v, d);
        end
        bus_write(13'h101C, 32'h1);
        exp_cfg[(0*ND+3)*DW +: DW] = 32'h016000FA;
        exp_wp = '0;
        exp_wp[3] = 1'b1;
        total++;
        if (commit_pulse !== 12'h001) begin
            bad++;
            $display("FAIL commit_pulse: got %h want 001", commit_pulse);
        end
        total++;
        if (wr_pulse !== exp_wp) begin
            bad++;
            $display("FAIL commit_wr_pulse: got %h want %h", wr_pulse, exp_wp);
        end
        total++;
        if (cfg_active[(0*ND+3)*DW +: DW] !== 32'h016000FA || cfg_active !== exp_cfg) begin
            bad++;
            $display("FAIL commit_active: slot3=%h diff bits=%0d, want 016000fa 0",
                     cfg_active[(0*ND+3)*DW +: DW], $countones(cfg_active ^ exp_cfg));
        end
        @(negedge clk);
        total++;
        if (commit_pulse !== '0 || wr_pulse !== '0) begin
            bad++;
            $display("FAIL pulse_width: commit=%h wr=%h, want 0 0", commit_pulse, wr_pulse);
        end
        bus_read(13'h101C, d, v, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL ctrl_selfclear: got %h want 00000000", d);
        end
        // Second commit with nothing new: commit pulses, no slot changed.
        bus_write(13'h101C, 32'h1);
        total++;
        if (commit_pulse !== 12'h001 || wr_pulse !== '0) begin
            bad++;
            $display("FAIL recommit: commit=%h wr=%h, want 001 0", commit_pulse, wr_pulse);
        end
    endtask

    task automatic test_auto();
        logic [DW-1:0] d;
        logic v, e;
        bus_write(13'h103C, 32'h2);
        total++;
        if (commit_pulse !== '0 || wr_pulse !== '0) begin
            bad++;
            $display("FAIL auto_set: commit=%h wr=%h, want 0 0", commit_pulse, wr_pulse);
        end
        bus_write(13'h1020, 32'h0085007D);
        exp_cfg[(1*ND+0)*DW +: DW] = 32'h0085007D;
        exp_wp = '0;
        exp_wp[7] = 1'b1;
        total++;
        if (cfg_active !== exp_cfg) begin
            bad++;
            $display("FAIL auto_active: ch1 slot0=%h, want 0085007d", cfg_active[ND*DW +: DW]);
        end
        total++;
        if (wr_pulse !== exp_wp) begin
            bad++;
            $display("FAIL auto_wr_pulse: got %h want %h", wr_pulse, exp_wp);
        end
        bus_read(13'h103C, d, v, e);
        total++;
        if (d !== 32'h2) begin
            bad++;
            $display("FAIL ctrl_auto_read: got %h want 00000002", d);
        end
        bus_read(13'h1020, d, v, e);
        total++;
        if (d !== 32'h0085007D) begin
            bad++;
            $display("FAIL auto_shadow_read: got %h want 0085007d", d);
        end
    endtask

    task automatic test_status();
        logic [DW-1:0] d;
        logic v, e;
        @(negedge clk);
        status_in[2*DW +: DW] = 32'h5;
        @(negedge clk);
        total++;
        if (evt_pending !== 12'h004 || irq !== 1'b0) begin
            bad++;
            $display("FAIL evt_set: evt=%h irq=%b, want 004 0", evt_pending, irq);
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_lag: got %b want 1", irq);
        end
        bus_read(13'h1240, d, v, e);
        total++;
        if (v !== 1'b1 || d !== 32'h5 || evt_pending !== '0) begin
            bad++;
            $display("FAIL status_read: valid=%b data=%h evt=%h, want 1 00000005 000",
                     v, d, evt_pending);
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear: got %b want 0", irq);
        end
        // Status moves in the same cycle the clearing read is accepted.
        req_valid = 1'b1;
        req_wren  = 1'b0;
        req_addr  = 13'h1240;
        status_in[2*DW +: DW] = 32'h9;
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (rd_data !== 32'h5 || evt_pending !== 12'h004) begin
            bad++;
            $display("FAIL set_wins: data=%h evt=%h, want 00000005 004", rd_data, evt_pending);
        end
        bus_read(13'h124C, d, v, e);
        total++;
        if (d !== 32'h9 || evt_pending !== '0) begin
            bad++;
            $display("FAIL status_anyreg: data=%h evt=%h, want 00000009 000", d, evt_pending);
        end
    endtask

    task automatic test_illegal();
        logic [DW-1:0] d;
        logic v, e;
        bus_write(13'h11A0, 32'hDEADBEEF);
        total++;
        if (err !== 1'b1 || cfg_active !== exp_cfg || wr_pulse !== '0) begin
            bad++;
            $display("FAIL ill_write: err=%b cfg diff bits=%0d wr=%h, want 1 0 0",
                     err, $countones(cfg_active ^ exp_cfg), wr_pulse);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_width: got %b want 0", err);
        end
        bus_read(13'h11A0, d, v, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
            bad++;
            $display("FAIL ill_read13: valid=%b data=%h err=%b, want 1 00000000 1", v, d, e);
        end
        bus_read(13'h1180, d, v, e);
        total++;
        if (v !== 1'b1 || e !== 1'b1) begin
            bad++;
            $display("FAIL ill_read12: valid=%b err=%b, want 1 1", v, e);
        end
        bus_read(13'h1160, d, v, e);
        total++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
            bad++;
            $display("FAIL legal_read11: valid=%b err=%b data=%h, want 1 0 00000000", v, e, d);
        end
        bus_read(13'h0004, d, v, e);
        total++;
        if (v !== 1'b0 || e !== 1'b0) begin
            bad++;
            $display("FAIL non_mmio_read: valid=%b err=%b, want 0 0", v, e);
        end
        bus_write(13'h003C, 32'h0);
        bus_read(13'h103C, d, v, e);
        total++;
        if (d !== 32'h2) begin
            bad++;
            $display("FAIL non_mmio_write: ch1 ctrl=%h want 00000002", d);
        end
    endtask

    task automatic test_reset_inflight();
        logic [DW-1:0] d;
        logic v, e;
        @(negedge clk);
        req_valid = 1'b1;
        req_wren  = 1'b0;
        req_addr  = 13'h1020;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        status_in = '0;
        exp_cfg   = '0;
        #1;
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0 || cfg_active !== '0) begin
            bad++;
            $display("FAIL async_reset: valid=%b data=%h cfg bits=%0d, want 0 00000000 0",
                     rd_valid, rd_data, $countones(cfg_active));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0 || cfg_active !== exp_cfg || evt_pending !== '0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: valid=%b cfg bits=%0d evt=%h irq=%b, want 0 0 000 0",
                     rd_valid, $countones(cfg_active), evt_pending, irq);
        end
        bus_read(13'h103C, d, v, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_auto: got %h want 00000000", d);
        end
        bus_read(13'h100C, d, v, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_shadow: got %h want 00000000", d);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wren  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        status_in = '0;
        exp_cfg   = '0;
        exp_wp    = '0;
        test_reset();
        test_manual_commit();
        test_auto();
        test_status();
        test_illegal();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
